// File: rtl/shift_seq.sv
// Sequencer for a chain of 74299-style universal shift registers: load, N shifts, then present the result.
// Optional rotate mode (MODE=10) is compiled in by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             REQ,
    input  logic             DIR,
    input  logic [1:0]       MODE,
    input  logic [AMT_W-1:0] AMT,
    input  logic             Q0,
    input  logic             Q7,
    output logic [1:0]       S,
    output logic [1:0]       N_OE,
    output logic             DSL,
    output logic             DSR,
    output logic             LOAD_OE,
    output logic             BUSY,
    output logic             VALID,
    input  logic             ACK
);

    // Chain width must be a whole number of chips.
    if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_bad_width
        $error("shift_seq: WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_OUT   = 2'b11
    } state_t;

    // Source of each serial-in pin; the data-carrying sources are chip feedback.
    typedef enum logic [1:0] {
        FILL_ZERO = 2'b00,
        FILL_ONE  = 2'b01,
        FILL_MSB  = 2'b10,
        FILL_LSB  = 2'b11
    } fill_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_LEFT  = 2'b01;
    localparam logic [1:0] S_RIGHT = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ONES  = 2'b11;
`ifdef SHIFT_SEQ_ROTATE_EN
    localparam logic [1:0] MODE_ROT   = 2'b10;
`endif

    state_t           state, state_nxt;
    logic [AMT_W-1:0] count, count_nxt;
    logic             dir_l, dir_nxt;
    logic [1:0]       mode_l, mode_nxt;

    logic [1:0]       s_nxt, n_oe_nxt;
    logic             load_oe_nxt, busy_nxt, valid_nxt;
    fill_t            dsl_sel, dsl_nxt, dsr_sel, dsr_nxt;

    // State and registered outputs.
    always_ff @(posedge CP) begin
        if (MR) begin
            state   <= ST_IDLE;
            count   <= '0;
            dir_l   <= 1'b0;
            mode_l  <= 2'b00;
            S       <= S_HOLD;
            N_OE    <= 2'b11;
            LOAD_OE <= 1'b0;
            BUSY    <= 1'b0;
            VALID   <= 1'b0;
            dsl_sel <= FILL_ZERO;
            dsr_sel <= FILL_ZERO;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            dir_l   <= dir_nxt;
            mode_l  <= mode_nxt;
            S       <= s_nxt;
            N_OE    <= n_oe_nxt;
            LOAD_OE <= load_oe_nxt;
            BUSY    <= busy_nxt;
            VALID   <= valid_nxt;
            dsl_sel <= dsl_nxt;
            dsr_sel <= dsr_nxt;
        end
    end

    // Next state, then output decode from the next state.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        dir_nxt     = dir_l;
        mode_nxt    = mode_l;
        s_nxt       = S_HOLD;
        n_oe_nxt    = 2'b11;
        load_oe_nxt = 1'b0;
        busy_nxt    = 1'b0;
        valid_nxt   = 1'b0;
        dsl_nxt     = FILL_ZERO;
        dsr_nxt     = FILL_ZERO;

        case (state)
            ST_IDLE: begin
                if (REQ) begin
                    dir_nxt   = DIR;
                    mode_nxt  = MODE;
                    count_nxt = AMT;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = (count == '0) ? ST_OUT : ST_SHIFT;
            end
            ST_SHIFT: begin
                count_nxt = count - AMT_W'(1);
                if (count <= AMT_W'(1)) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (ACK) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);

        case (state_nxt)
            ST_LOAD: begin
                s_nxt       = S_LOAD;
                load_oe_nxt = 1'b1;
            end
            ST_SHIFT: begin
                s_nxt = dir_nxt ? S_RIGHT : S_LEFT;
                // Only the pin on the active side carries fill.
                case (mode_nxt)
                    MODE_ARITH: begin
                        if (dir_nxt) dsr_nxt = FILL_MSB;
                    end
`ifdef SHIFT_SEQ_ROTATE_EN
                    MODE_ROT: begin
                        if (dir_nxt) dsr_nxt = FILL_LSB;
                        else         dsl_nxt = FILL_MSB;
                    end
`endif
                    MODE_ONES: begin
                        if (dir_nxt) dsr_nxt = FILL_ONE;
                        else         dsl_nxt = FILL_ONE;
                    end
                    default: ;
                endcase
            end
            ST_OUT: begin
                n_oe_nxt  = 2'b00;
                valid_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Serial-in pins: registered source select gating the live chip feedback.
`ifdef SHIFT_SEQ_ROTATE_EN
    assign DSL = (dsl_sel == FILL_ONE) | ((dsl_sel == FILL_MSB) & Q7);
    assign DSR = (dsr_sel == FILL_ONE) | ((dsr_sel == FILL_MSB) & Q7)
               | ((dsr_sel == FILL_LSB) & Q0);
`else
    assign DSL = (dsl_sel == FILL_ONE);
    assign DSR = (dsr_sel == FILL_ONE) | ((dsr_sel == FILL_MSB) & Q7);

    logic unused_q0;
    assign unused_q0 = Q0;
`endif

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: behavioural 8-bit 74299 chain model plus hand-computed results.
`timescale 1ns/1ps
module tb_shift_seq;

    logic       CP = 1'b0;
    logic       MR = 1'b1;
    logic       REQ = 1'b0;
    logic       DIR = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [2:0] AMT = 3'd0;
    logic       Q0, Q7;
    logic [1:0] S, N_OE;
    logic       DSL, DSR, LOAD_OE, BUSY, VALID;
    logic       ACK = 1'b0;

    logic [7:0] operand = 8'h00;
    logic [7:0] chip = 8'h00;

    int total = 0;
    int bad = 0;
    int loads = 0;
    int shifts = 0;
    int overlap = 0;

    shift_seq #(.WIDTH(8), .AMT_W(3)) dut (
        .CP(CP), .MR(MR), .REQ(REQ), .DIR(DIR), .MODE(MODE), .AMT(AMT),
        .Q0(Q0), .Q7(Q7), .S(S), .N_OE(N_OE), .DSL(DSL), .DSR(DSR),
        .LOAD_OE(LOAD_OE), .BUSY(BUSY), .VALID(VALID), .ACK(ACK)
    );

    always #5 CP = ~CP;

    // Chain model: load from the operand bus, shift with serial ins.
    assign Q0 = chip[0];
    assign Q7 = chip[7];
    always @(posedge CP) begin
        case (S)
            2'b11:   if (LOAD_OE) chip <= operand;
            2'b01:   chip <= {chip[6:0], DSL};
            2'b10:   chip <= {DSR, chip[7:1]};
            default: ;
        endcase
    end

    // Cycle monitor.
    always @(negedge CP) begin
        if (LOAD_OE) loads++;
        if (S == 2'b01 || S == 2'b10) shifts++;
        if (LOAD_OE && N_OE != 2'b11) overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One complete operation: request, wait for VALID, hold, acknowledge.
    task automatic run_op(input string tag, input logic [7:0] op, input logic dir,
                          input logic [1:0] mode, input logic [2:0] amt,
                          input logic [7:0] exp, input int hold);
        int edges;
        logic got;
        @(negedge CP);
        operand = op; DIR = dir; MODE = mode; AMT = amt; REQ = 1'b1;
        loads = 0; shifts = 0; edges = 0; got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge CP);
            edges++;
            @(negedge CP);
            REQ = 1'b0;
            if (VALID) got = 1'b1;
        end
        check_eq({tag, "_lat"}, 32'(edges), 32'(2 + int'(amt)));
        check_eq({tag, "_loads"}, 32'(loads), 32'd1);
        check_eq({tag, "_shifts"}, 32'(shifts), 32'(amt));
        check_eq({tag, "_noe"}, 32'(N_OE), 32'd0);
        check_eq({tag, "_res"}, 32'(chip), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge CP);
            @(negedge CP);
        end
        if (hold > 0) begin
            check_eq({tag, "_hold_valid"}, 32'(VALID), 32'd1);
            check_eq({tag, "_hold_res"}, 32'(chip), 32'(exp));
        end
        ACK = 1'b1;
        @(posedge CP);
        @(negedge CP);
        ACK = 1'b0;
        check_eq({tag, "_ack_valid"}, 32'(VALID), 32'd0);
        check_eq({tag, "_ack_busy"}, 32'(BUSY), 32'd0);
        check_eq({tag, "_ack_noe"}, 32'(N_OE), 32'd3);
    endtask

    initial begin
        int edges;
        logic [7:0] rot_exp;

        // Reset state.
        repeat (2) @(posedge CP);
        @(negedge CP);
        check_eq("rst_s", 32'(S), 32'd0);
        check_eq("rst_noe", 32'(N_OE), 32'd3);
        check_eq("rst_load_oe", 32'(LOAD_OE), 32'd0);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_valid", 32'(VALID), 32'd0);
        check_eq("rst_dsl_dsr", 32'({DSL, DSR}), 32'd0);
        MR = 1'b0;

        // Reset mid-shift, then a normal operation.
        @(negedge CP);
        operand = 8'h96; DIR = 1'b0; MODE = 2'b00; AMT = 3'd5; REQ = 1'b1;
        @(posedge CP);
        @(negedge CP);
        REQ = 1'b0;
        repeat (3) @(posedge CP);
        @(negedge CP);
        check_eq("mid_busy_before", 32'(BUSY), 32'd1);
        MR = 1'b1;
        @(posedge CP);
        @(negedge CP);
        MR = 1'b0;
        check_eq("mid_rst_s", 32'(S), 32'd0);
        check_eq("mid_rst_noe", 32'(N_OE), 32'd3);
        check_eq("mid_rst_busy", 32'(BUSY), 32'd0);
        check_eq("mid_rst_valid", 32'(VALID), 32'd0);
        run_op("after_rst", 8'h96, 1'b0, 2'b11, 3'd2, 8'h5B, 0);

        // Main function.
        run_op("lsl3", 8'h96, 1'b0, 2'b00, 3'd3, 8'hB0, 0);
        run_op("asr2", 8'h96, 1'b1, 2'b01, 3'd2, 8'hE5, 0);
        run_op("lsr2", 8'h96, 1'b1, 2'b00, 3'd2, 8'h25, 0);
        run_op("asl1", 8'h96, 1'b0, 2'b01, 3'd1, 8'h2C, 0);
        run_op("amt0", 8'h5A, 1'b0, 2'b00, 3'd0, 8'h5A, 4);
        run_op("lsl7", 8'hFF, 1'b0, 2'b00, 3'd7, 8'h80, 0);
        run_op("ones_r7", 8'h00, 1'b1, 2'b11, 3'd7, 8'hFE, 0);
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_exp = 8'h03;
`else
        rot_exp = 8'h02;
`endif
        run_op("rot_l1", 8'h81, 1'b0, 2'b10, 3'd1, rot_exp, 0);

        // Back-to-back with REQ held high.
        @(negedge CP);
        operand = 8'h96; DIR = 1'b0; MODE = 2'b00; AMT = 3'd1; REQ = 1'b1;
        edges = 0;
        while (!VALID && edges < 40) begin
            @(posedge CP);
            edges++;
            @(negedge CP);
        end
        check_eq("b2b_first_lat", 32'(edges), 32'd3);
        check_eq("b2b_first_res", 32'(chip), 32'h2C);
        ACK = 1'b1;
        operand = 8'h5A; AMT = 3'd0;
        @(posedge CP);
        @(negedge CP);
        ACK = 1'b0;
        check_eq("b2b_idle_busy", 32'(BUSY), 32'd0);
        check_eq("b2b_idle_load_oe", 32'(LOAD_OE), 32'd0);
        @(posedge CP);
        @(negedge CP);
        REQ = 1'b0;
        check_eq("b2b_load_oe", 32'(LOAD_OE), 32'd1);
        check_eq("b2b_load_busy", 32'(BUSY), 32'd1);
        @(posedge CP);
        @(negedge CP);
        check_eq("b2b_second_valid", 32'(VALID), 32'd1);
        check_eq("b2b_second_res", 32'(chip), 32'h5A);
        ACK = 1'b1;
        @(posedge CP);
        @(negedge CP);
        ACK = 1'b0;
        check_eq("b2b_done_valid", 32'(VALID), 32'd0);

        check_eq("oe_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
